// File: rtl/buff_drain.sv
// Drains an external buffer through a 2-entry registered skid FIFO.
// Tracks the buffer's occupancy itself and flags sticky overflow.
module buff_drain #(
  parameter int NUMELEM = 4,
  parameter int BITDATA = 4,
  localparam int BITELEM = $clog2(NUMELEM)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  output logic               pop,
  input  logic [BITDATA-1:0] po_dout,
  output logic               out_valid,
  output logic [BITDATA-1:0] out_data,
  input  logic               out_ready,
  output logic [BITELEM:0]   occ,
  output logic               empty,
  output logic               full,
  output logic               ovf_err
);

  localparam logic [BITELEM:0] OCC_FULL = (BITELEM+1)'(NUMELEM);
  localparam logic [BITELEM:0] OCC_ONE  = (BITELEM+1)'(1);

  logic [BITELEM:0]   r_occ;
  logic [1:0]         r_skid_cnt;
  logic [BITDATA-1:0] r_skid0;
  logic [BITDATA-1:0] r_skid1;
  logic               r_ovf;

  logic               w_pop;
  logic               w_xfer;
  logic               w_full;
  logic [1:0]         w_cnt_after;
  logic [1:0]         w_cnt_nxt;
  logic [BITDATA-1:0] w_skid0_nxt;
  logic [BITDATA-1:0] w_skid1_nxt;
  logic [BITELEM:0]   w_occ_nxt;
  logic               w_ovf_nxt;

  // Output handshake: a word moves when out_valid && out_ready on a rising
  // edge; out_valid never waits for out_ready and out_data holds until taken.
  // Pop looks only at registered state, so a push is never bypassed to pop.
  assign w_pop       = (r_occ != '0) && (r_skid_cnt != 2'd2);
  assign w_xfer      = (r_skid_cnt != 2'd0) && out_ready;
  assign w_full      = (r_occ == OCC_FULL);
  assign w_cnt_after = r_skid_cnt - {1'b0, w_xfer};
  assign w_cnt_nxt   = w_cnt_after + {1'b0, w_pop};

  always_comb begin
    w_skid0_nxt = r_skid0;
    w_skid1_nxt = r_skid1;
    if (w_xfer) begin
      w_skid0_nxt = r_skid1;
    end
    // Popped data lands at the tail as seen after this cycle's transfer.
    if (w_pop) begin
      if (w_cnt_after == 2'd0) begin
        w_skid0_nxt = po_dout;
      end else begin
        w_skid1_nxt = po_dout;
      end
    end
  end

  always_comb begin
    w_occ_nxt = r_occ;
    w_ovf_nxt = r_ovf;
    case ({push, w_pop})
      2'b10: begin
        if (w_full) begin
          w_ovf_nxt = 1'b1;
        end else begin
          w_occ_nxt = r_occ + OCC_ONE;
        end
      end
      2'b01:   w_occ_nxt = r_occ - OCC_ONE;
      default: w_occ_nxt = r_occ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_occ      <= '0;
      r_skid_cnt <= 2'd0;
      r_skid0    <= '0;
      r_skid1    <= '0;
      r_ovf      <= 1'b0;
    end else begin
      r_occ      <= w_occ_nxt;
      r_skid_cnt <= w_cnt_nxt;
      r_skid0    <= w_skid0_nxt;
      r_skid1    <= w_skid1_nxt;
      r_ovf      <= w_ovf_nxt;
    end
  end

  assign pop       = w_pop;
  assign out_valid = (r_skid_cnt != 2'd0);
  assign out_data  = r_skid0;
  assign occ       = r_occ;
  assign empty     = (r_occ == '0);
  assign full      = w_full;
  assign ovf_err   = r_ovf;

endmodule

// File: tb/tb_buff_drain.sv
// Bench for buff_drain: upstream buffer and skid modelled with queues,
// output order checked against the push-order queue.
module tb_buff_drain;
  localparam int NUMELEM = 4;
  localparam int BITDATA = 4;
  localparam int BITOCC  = $clog2(NUMELEM) + 1;

  logic               clk = 1'b0;
  logic               rst;
  logic               push;
  logic               out_ready;
  logic [BITDATA-1:0] po_dout;
  logic               pop;
  logic               out_valid;
  logic [BITDATA-1:0] out_data;
  logic [BITOCC-1:0]  occ;
  logic               empty;
  logic               full;
  logic               ovf_err;

  buff_drain #(.NUMELEM(NUMELEM), .BITDATA(BITDATA)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .po_dout(po_dout),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .occ(occ), .empty(empty), .full(full), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  logic [BITDATA-1:0] up_q[$];
  logic [BITDATA-1:0] sk_q[$];
  logic [BITDATA-1:0] exp_q[$];
  logic               ovf_m;

  logic               s_pop, s_valid, s_full, s_empty, s_ovf;
  logic [BITDATA-1:0] s_data;
  logic [BITOCC-1:0]  s_occ;
  logic               e_pop, e_valid, e_full, e_empty, e_ovf, e_xfer;
  logic [BITDATA-1:0] e_data, e_order;
  logic [BITOCC-1:0]  e_occ;

  int checks = 0;
  int passed = 0;

  // One clock cycle: drive at posedge+1, sample at negedge, advance model.
  task automatic step(input logic p, input logic [BITDATA-1:0] d, input logic r);
    logic full_before;
    push      = p;
    out_ready = r;
    po_dout   = (up_q.size() != 0) ? up_q[0] : '0;
    @(negedge clk);
    s_pop = pop; s_valid = out_valid; s_data = out_data; s_occ = occ;
    s_full = full; s_empty = empty; s_ovf = ovf_err;
    e_pop   = (up_q.size() != 0) && (sk_q.size() < 2);
    e_valid = (sk_q.size() != 0);
    e_data  = e_valid ? sk_q[0] : '0;
    e_occ   = BITOCC'(up_q.size());
    e_empty = (up_q.size() == 0);
    e_full  = (up_q.size() == NUMELEM);
    e_ovf   = ovf_m;
    e_xfer  = e_valid && r;
    e_order = '0;
    if (e_xfer && exp_q.size() != 0) e_order = exp_q.pop_front();
    full_before = e_full;
    @(posedge clk);
    #1;
    if (e_xfer) void'(sk_q.pop_front());
    if (e_pop) sk_q.push_back(up_q.pop_front());
    if (p) begin
      if (full_before && !e_pop) begin
        ovf_m = 1'b1;
      end else begin
        up_q.push_back(d);
        exp_q.push_back(d);
      end
    end
    push = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0; push = 1'b0; out_ready = 1'b0; po_dout = '0;
    up_q.delete(); sk_q.delete(); exp_q.delete(); ovf_m = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; push = 1'b0; out_ready = 1'b0; po_dout = '0;
    #1 rst = 1'b0;
    #2;
    checks++; if (occ !== '0) $display("FAIL reset_occ got=%0d exp=0", occ); else passed++;
    checks++; if (pop !== 1'b0) $display("FAIL reset_pop got=%b exp=0", pop); else passed++;
    checks++; if (out_valid !== 1'b0 || out_data !== '0) $display("FAIL reset_out got v=%b d=%h exp v=0 d=0", out_valid, out_data); else passed++;
    checks++; if (empty !== 1'b1 || full !== 1'b0 || ovf_err !== 1'b0) $display("FAIL reset_flags got e=%b f=%b o=%b exp 1 0 0", empty, full, ovf_err); else passed++;
    do_reset();
  endtask

  task automatic test_single();
    step(1'b1, 4'hA, 1'b1);
    checks++; if (s_pop !== 1'b0 || s_occ !== '0) $display("FAIL single_c1 got pop=%b occ=%0d exp 0 0", s_pop, s_occ); else passed++;
    step(1'b0, '0, 1'b1);
    checks++; if (s_pop !== 1'b1 || s_occ !== 3'd1 || s_valid !== 1'b0) $display("FAIL single_c2 got pop=%b occ=%0d v=%b exp 1 1 0", s_pop, s_occ, s_valid); else passed++;
    step(1'b0, '0, 1'b1);
    checks++; if (s_valid !== 1'b1 || s_data !== 4'hA || s_occ !== '0) $display("FAIL single_c3 got v=%b d=%h occ=%0d exp 1 a 0", s_valid, s_data, s_occ); else passed++;
    step(1'b0, '0, 1'b1);
    checks++; if (s_valid !== 1'b0) $display("FAIL single_c4 got v=%b exp 0", s_valid); else passed++;
  endtask

  task automatic test_backpressure();
    int pops = 0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(i < 3, BITDATA'(i + 1), 1'b0);
      pops += int'(s_pop);
      if (i >= 3) begin
        checks++; if (s_valid !== 1'b1 || s_data !== 4'h1) $display("FAIL bp_hold cyc=%0d got v=%b d=%h exp 1 1", i, s_valid, s_data); else passed++;
      end
    end
    checks++; if (pops != 2) $display("FAIL bp_pops got=%0d exp=2", pops); else passed++;
    checks++; if (s_occ !== 3'd1 || s_pop !== 1'b0) $display("FAIL bp_state got occ=%0d pop=%b exp 1 0", s_occ, s_pop); else passed++;
    for (int k = 0; k < 4; k++) begin
      step(1'b0, '0, 1'b1);
      checks++;
      if (s_valid !== (k < 3) || (k < 3 && s_data !== BITDATA'(k + 1)))
        $display("FAIL bp_drain k=%0d got v=%b d=%h exp v=%b d=%0d", k, s_valid, s_data, k < 3, k + 1);
      else passed++;
    end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b1, BITDATA'(i), 1'b0);
    step(1'b0, '0, 1'b0);
    checks++; if (s_occ !== 3'd4 || s_full !== 1'b1 || s_ovf !== 1'b0) $display("FAIL fill_full got occ=%0d f=%b o=%b exp 4 1 0", s_occ, s_full, s_ovf); else passed++;
    step(1'b1, 4'h6, 1'b0);
    step(1'b1, 4'h7, 1'b0);
    step(1'b0, '0, 1'b0);
    checks++; if (s_ovf !== 1'b1 || s_occ !== 3'd4) $display("FAIL fill_ovf got o=%b occ=%0d exp 1 4", s_ovf, s_occ); else passed++;
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1);
    checks++; if (s_ovf !== 1'b1 || s_empty !== 1'b1) $display("FAIL fill_sticky got o=%b e=%b exp 1 1", s_ovf, s_empty); else passed++;
  endtask

  task automatic test_stream();
    do_reset();
    for (int c = 0; c < 20; c++) begin
      step(c < 16, BITDATA'(c), 1'b1);
      checks++; if (s_occ > 3'd1) $display("FAIL stream_occ c=%0d got=%0d exp<=1", c, s_occ); else passed++;
      checks++;
      if (s_valid !== (c >= 2 && c < 18) || (c >= 2 && c < 18 && s_data !== BITDATA'(c - 2)))
        $display("FAIL stream_out c=%0d got v=%b d=%h exp v=%b d=%0d", c, s_valid, s_data, c >= 2 && c < 18, c - 2);
      else passed++;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, BITDATA'(i + 1), 1'b0);
    #2 rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || occ !== '0 || pop !== 1'b0) $display("FAIL rmid_async got v=%b occ=%0d pop=%b exp 0 0 0", out_valid, occ, pop); else passed++;
    up_q.delete(); sk_q.delete(); exp_q.delete(); ovf_m = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0, 1'b1);
      checks++; if (s_valid !== 1'b0 || s_pop !== 1'b0) $display("FAIL rmid_idle i=%0d got v=%b pop=%b exp 0 0", i, s_valid, s_pop); else passed++;
    end
    step(1'b1, 4'h7, 1'b1);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    checks++; if (s_valid !== 1'b1 || s_data !== 4'h7) $display("FAIL rmid_new got v=%b d=%h exp 1 7", s_valid, s_data); else passed++;
  endtask

  task automatic test_random();
    int push_pct, ready_pct;
    for (int ph = 0; ph < 2; ph++) begin
      do_reset();
      push_pct  = (ph == 0) ? 50 : 80;
      ready_pct = (ph == 0) ? 80 : 30;
      for (int c = 0; c < 300; c++) begin
        step($urandom_range(0, 99) < push_pct, BITDATA'($urandom_range(0, 15)),
             $urandom_range(0, 99) < ready_pct);
        checks++; if (s_occ !== e_occ) $display("FAIL rnd_occ c=%0d got=%0d exp=%0d", c, s_occ, e_occ); else passed++;
        checks++; if (s_pop !== e_pop) $display("FAIL rnd_pop c=%0d got=%b exp=%b", c, s_pop, e_pop); else passed++;
        checks++; if (s_valid !== e_valid) $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, s_valid, e_valid); else passed++;
        checks++; if (s_full !== e_full || s_empty !== e_empty || s_ovf !== e_ovf) $display("FAIL rnd_flags c=%0d got f=%b e=%b o=%b exp %b %b %b", c, s_full, s_empty, s_ovf, e_full, e_empty, e_ovf); else passed++;
        if (e_valid) begin
          checks++; if (s_data !== e_data) $display("FAIL rnd_data c=%0d got=%h exp=%h", c, s_data, e_data); else passed++;
        end
        if (e_xfer) begin
          checks++; if (s_data !== e_order) $display("FAIL rnd_order c=%0d got=%h exp=%h", c, s_data, e_order); else passed++;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_fill();
    test_stream();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached passed=%0d total=%0d", passed, checks);
    $fatal(1);
  end

endmodule

// File: doc/buff_drain.md
BUFF_DRAIN -- requirements
Module: buff_drain

Interface
REQ-001 Parameter NUMELEM, default 4, number of entries in the upstream buffer this block drains.
REQ-002 Parameter BITDATA, default 4, width of each data element.
REQ-003 Localparam BITELEM = $clog2(NUMELEM); occupancy width is BITELEM+1.
REQ-004 One clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  sole clock; all state changes on rising edge.
REQ-006 rst  input  1  asynchronous active-low reset (0 = reset asserted).
REQ-007 push  input  1  copy of the upstream buffer's push strobe, one element entering per cycle when high.
REQ-008 pop  output  1  pop strobe to the upstream buffer.
REQ-009 po_dout  input  BITDATA  upstream buffer head data, valid in the same cycle pop is high.
REQ-010 out_valid  output  1  output stream valid.
REQ-011 out_data  output  BITDATA  output stream data.
REQ-012 out_ready  input  1  downstream accepts out_data when out_valid and out_ready are both high.
REQ-013 occ  output  BITELEM+1  registered count of elements held in the upstream buffer.
REQ-014 empty  output  1  occ == 0.
REQ-015 full  output  1  occ == NUMELEM.
REQ-016 ovf_err  output  1  sticky overflow flag.

Function
REQ-017 occ update per cycle: push only -> +1; pop only -> -1; both or neither -> unchanged.
REQ-018 pop SHALL be combinational: pop = (occ != 0) && (skid_cnt < 2), using registered values only; pop SHALL NOT depend on push or out_ready in the same cycle.
REQ-019 An element pushed in cycle t SHALL NOT be popped before cycle t+1 (no same-cycle bypass).
REQ-020 Internal 2-entry skid FIFO (skid_cnt 0..2) holds popped data; in any cycle with pop high, po_dout SHALL be written at the skid tail.
REQ-021 out_valid = (skid_cnt != 0); out_data = skid head entry, registered; no combinational path from po_dout to out_data.
REQ-022 A transfer (out_valid && out_ready) SHALL remove the head; simultaneous pop and transfer leaves skid_cnt unchanged and preserves order.
REQ-023 out_data SHALL remain stable while out_valid is high and out_ready is low.
REQ-024 Latency: push in cycle t with occ==0, skid empty, out_ready high -> pop in t+1 -> out_valid with that data in t+2.
REQ-025 Sustained throughput: with out_ready held high and push every cycle, pop and transfer SHALL each occur every cycle after the 2-cycle fill.
REQ-026 Push while occ == NUMELEM and pop low: occ SHALL stay NUMELEM, ovf_err SHALL set at next edge and remain set until reset.
REQ-027 Push while occ == NUMELEM and pop high: legal; occ unchanged, ovf_err unaffected.
REQ-028 Element order at out_data SHALL equal push order; no element duplicated or dropped, except on overflow.

Reset
REQ-029 While rst is low: occ=0, skid_cnt=0, out_valid=0, out_data=0, ovf_err=0, and therefore pop=0, empty=1, full=0.
REQ-030 Reset asserted mid-operation SHALL discard skid contents immediately (asynchronously); the first pop after deassertion SHALL require a new push.
REQ-031 The first rising edge with rst high SHALL be the first edge on which state can change.

Verification
REQ-032 Single element: push with data 0xA in cycle 1 -> pop=1 in cycle 2 -> out_valid=1, out_data=0xA in cycle 3; occ returns to 0 in cycle 3.
REQ-033 Backpressure: out_ready=0, push 0x1,0x2,0x3 on consecutive cycles -> exactly two pops, skid_cnt=2, occ=1, pop=0 thereafter; raise out_ready -> outputs 0x1,0x2,0x3 in order, one per cycle.
REQ-034 Fill to full: NUMELEM=4, out_ready=0, push 6 elements -> occ=4, full=1, ovf_err=0, because two elements drain into the skid; push 2 more -> ovf_err=1 and stays 1.
REQ-035 Streaming: out_ready=1, push 0..15 every cycle -> out_data 0..15 on consecutive cycles starting 2 cycles after the first push; occ never exceeds 1.
REQ-036 Reset mid-stream: with skid_cnt=2 and occ=3, drive rst=0 between edges -> out_valid=0, occ=0, pop=0 immediately; after release, no output until a new push.
REQ-037 Random push/out_ready with a reference queue model -> out_data order matches and occ equals model count every cycle.
